// File: rtl/Vermicel_pkg.sv
// Vermicel SoC-level definitions used by the bus arbiter.
package Vermicel_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int ARB_TIMEOUT_DEFAULT = 256;
endpackage

// File: rtl/Vermitypes_pkg.sv
// Shared Vermibus data types: bus word and byte-enable strobe.
package Vermitypes_pkg;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  strobe_t;
endpackage

// File: rtl/vermibus_watchdog.sv
// Wait-cycle counter for a bus master: counts enabled cycles, clears on
// request, and flags when the count has reached TIMEOUT-1 (never when 0).
module vermibus_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam logic [15:0] LIMIT = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  logic [15:0] cnt_d;
  logic [15:0] cnt_q;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 16'd0;
    end else if (en) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT > 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/vermibus_arbiter.sv
// Two-master Vermibus arbiter: registered round-robin grant held for one
// transfer, with a watchdog that aborts transfers the slave never acknowledges.
module vermibus_arbiter
  import Vermitypes_pkg::*;
  import Vermicel_pkg::*;
#(
  parameter int TIMEOUT  = ARB_TIMEOUT_DEFAULT,
  parameter bit M0_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_valid,
  input  word_t      m0_address,
  input  word_t      m0_wdata,
  input  strobe_t    m0_wstrobe,
  output logic       m0_ready,
  output word_t      m0_rdata,
  output logic       m0_irq,
  input  logic       m1_valid,
  input  word_t      m1_address,
  input  word_t      m1_wdata,
  input  strobe_t    m1_wstrobe,
  output logic       m1_ready,
  output word_t      m1_rdata,
  output logic       s_valid,
  output word_t      s_address,
  output word_t      s_wdata,
  output strobe_t    s_wstrobe,
  input  logic       s_ready,
  input  word_t      s_rdata,
  input  logic       s_irq,
  output logic       timeout,
  output logic [1:0] grant
);

  // Pointer value 0 prefers M0, 1 prefers M1.
  localparam logic PTR_RESET = M0_FIRST ? 1'b0 : 1'b1;

  arb_state_t state_d;
  arb_state_t state_q;
  logic       ptr_d;
  logic       ptr_q;
  logic [1:0] grant_d;
  logic [1:0] grant_q;
  logic       s_valid_d;
  logic       s_valid_q;

  logic owning_s;
  logic expired_s;
  logic done_s;
  logic abort_s;

  assign owning_s = (state_q != IDLE);
  // A same-cycle completion beats the watchdog.
  assign abort_s  = owning_s && expired_s && !s_ready;
  assign done_s   = owning_s && (s_ready || expired_s);

  vermibus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (reset),
    .en      (owning_s && !s_ready),
    .clr     (!owning_s || done_s),
    .expired (expired_s)
  );

  // Next owner and round-robin pointer; IDLE is visited between transfers.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          state_d = ptr_q ? OWN1 : OWN0;
        end else if (m0_valid) begin
          state_d = OWN0;
        end else if (m1_valid) begin
          state_d = OWN1;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0: begin
        if (done_s) begin
          state_d = IDLE;
          ptr_d   = 1'b1;
        end else begin
          state_d = OWN0;
        end
      end
      OWN1: begin
        if (done_s) begin
          state_d = IDLE;
          ptr_d   = 1'b0;
        end else begin
          state_d = OWN1;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = ptr_q;
      end
    endcase
    grant_d   = {state_d == OWN1, state_d == OWN0};
    s_valid_d = (state_d != IDLE);
  end

  // FSM, pointer and registered grant/request outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_RESET;
      grant_q   <= 2'b00;
      s_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      s_valid_q <= s_valid_d;
    end
  end

  // Slave-side payload mux and response steering on the registered owner.
  always_comb begin
    s_address = 32'h0000_0000;
    s_wdata   = 32'h0000_0000;
    s_wstrobe = 4'b0000;
    m0_ready  = 1'b0;
    m0_rdata  = 32'h0000_0000;
    m1_ready  = 1'b0;
    m1_rdata  = 32'h0000_0000;
    case (state_q)
      OWN0: begin
        s_address = m0_address;
        s_wdata   = m0_wdata;
        s_wstrobe = m0_wstrobe;
        m0_ready  = done_s;
        m0_rdata  = abort_s ? 32'h0000_0000 : s_rdata;
      end
      OWN1: begin
        s_address = m1_address;
        s_wdata   = m1_wdata;
        s_wstrobe = m1_wstrobe;
        m1_ready  = done_s;
        m1_rdata  = abort_s ? 32'h0000_0000 : s_rdata;
      end
      default: begin
        s_address = 32'h0000_0000;
      end
    endcase
  end

  assign s_valid = s_valid_q;
  assign grant   = grant_q;
  assign timeout = abort_s;
  assign m0_irq  = s_irq;

endmodule

// File: tb/tb_vermibus_arbiter.sv
// Randomised scoreboard bench for vermibus_arbiter with TIMEOUT = 8.
module tb_vermibus_arbiter;

  localparam int TMO = 8;

  typedef struct {
    logic [31:0] rd;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mv;
  logic [31:0] maddr [2];
  logic [31:0] mwd   [2];
  logic [3:0]  mst   [2];
  logic        m0_ready, m1_ready, m0_irq;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready, s_irq, timeout;
  logic [31:0] s_address, s_wdata, s_rdata;
  logic [3:0]  s_wstrobe;
  logic [1:0]  grant;

  int nchk = 0;
  int nfail = 0;
  int txn_id = 0;
  exp_t q0[$];
  exp_t q1[$];
  int          lat_map [logic [31:0]];
  logic [31:0] dat_map [logic [31:0]];

  always #5 clk = ~clk;

  vermibus_arbiter #(.TIMEOUT(TMO), .M0_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(mv[0]), .m0_address(maddr[0]), .m0_wdata(mwd[0]), .m0_wstrobe(mst[0]),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_irq(m0_irq),
    .m1_valid(mv[1]), .m1_address(maddr[1]), .m1_wdata(mwd[1]), .m1_wstrobe(mst[1]),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_address(s_address), .s_wdata(s_wdata), .s_wstrobe(s_wstrobe),
    .s_ready(s_ready), .s_rdata(s_rdata), .s_irq(s_irq),
    .timeout(timeout), .grant(grant)
  );

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    chk32(name, 32'(act), 32'(req));
  endtask

  // Drive a request from master n and register how the slave will answer it.
  task automatic setup(input int n, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input int lat, input logic [31:0] rd);
    exp_t e;
    lat_map[a] = lat;
    dat_map[a] = rd;
    e.rd = (lat < TMO) ? rd : 32'h0;
    e.to = (lat >= TMO);
    if (n == 0) q0.push_back(e);
    else q1.push_back(e);
    maddr[n] = a;
    mwd[n]   = wd;
    mst[n]   = st;
    mv[n]    = 1'b1;
  endtask

  task automatic await_rdy(input int n);
    int   k = 0;
    logic r = 1'b0;
    do begin
      @(negedge clk);
      k++;
      r = (n == 0) ? m0_ready : m1_ready;
    end while (!r && k < 200);
    if (!r) begin
      nchk++;
      nfail++;
      $display("FAIL await_m%0d: no ready after %0d cycles, required ready=1", n, k);
    end
    @(posedge clk);
    #1;
    mv[n] = 1'b0;
  endtask

  task automatic issue(input int n, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input int lat, input logic [31:0] rd);
    setup(n, a, wd, st, lat, rd);
    await_rdy(n);
  endtask

  task automatic rnd_issue(input int n);
    int r;
    int lat;
    logic [31:0] a;
    r = int'($urandom_range(0, 9));
    case (r)
      6: lat = TMO - 1;
      7: lat = TMO;
      8: lat = 6;
      9: lat = 30;
      default: lat = r;
    endcase
    a = 32'h4000_0000 | (32'(n) << 20) | (32'(txn_id) << 2);
    txn_id++;
    issue(n, a, $urandom(), 4'($urandom()), lat, $urandom());
  endtask

  // Slave model: answers each transfer after the latency registered for its address.
  task automatic slave_loop();
    int          cnt = 0;
    int          lat = 0;
    bit          active = 1'b0;
    logic [31:0] rd = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      s_irq = 1'($urandom());
      if (s_valid) begin
        if (!active) begin
          active = 1'b1;
          cnt    = 0;
          lat    = lat_map.exists(s_address) ? lat_map[s_address] : 0;
          rd     = dat_map.exists(s_address) ? dat_map[s_address] : 32'h0;
        end else begin
          cnt++;
        end
        s_ready = (cnt == lat);
        s_rdata = s_ready ? rd : $urandom();
      end else begin
        active  = 1'b0;
        s_ready = 1'b0;
        s_rdata = $urandom();
      end
    end
  endtask

  // Reference: owner/pointer rules plus the response scoreboard.
  task automatic monitor_loop();
    int   owner = -1;
    int   ptr = 0;
    int   waitc = 0;
    logic done;
    exp_t e;
    forever begin
      @(negedge clk);
      chk1("irq_pass", m0_irq, s_irq);
      if (!reset) begin
        owner = -1;
        ptr   = 0;
        waitc = 0;
        q0.delete();
        q1.delete();
        chk1("rst_s_valid", s_valid, 1'b0);
        chk32("rst_grant", 32'(grant), 32'h0);
        chk1("rst_m0_ready", m0_ready, 1'b0);
        chk1("rst_m1_ready", m1_ready, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
      end else begin
        if (owner < 0) begin
          chk1("idle_s_valid", s_valid, 1'b0);
          chk32("idle_grant", 32'(grant), 32'h0);
          chk1("idle_m0_ready", m0_ready, 1'b0);
          chk1("idle_m1_ready", m1_ready, 1'b0);
          chk1("idle_timeout", timeout, 1'b0);
          if (mv == 2'b11) owner = ptr;
          else if (mv[0]) owner = 0;
          else if (mv[1]) owner = 1;
          else owner = -1;
          waitc = 0;
        end else begin
          done = s_ready || (waitc == TMO - 1);
          chk1("own_s_valid", s_valid, 1'b1);
          chk32("own_grant", 32'(grant), (owner == 1) ? 32'h2 : 32'h1);
          chk32("own_s_address", s_address, maddr[owner]);
          chk32("own_s_wdata", s_wdata, mwd[owner]);
          chk32("own_s_wstrobe", 32'(s_wstrobe), 32'(mst[owner]));
          chk1("own_timeout", timeout, !s_ready && (waitc == TMO - 1));
          if (owner == 0) begin
            chk1("own_m0_ready", m0_ready, done);
            chk1("other_m1_ready", m1_ready, 1'b0);
            chk32("other_m1_rdata", m1_rdata, 32'h0);
          end else begin
            chk1("own_m1_ready", m1_ready, done);
            chk1("other_m0_ready", m0_ready, 1'b0);
            chk32("other_m0_rdata", m0_rdata, 32'h0);
          end
          if (done) begin
            ptr   = 1 - owner;
            owner = -1;
          end else begin
            waitc++;
          end
        end
        if (m0_ready) begin
          if (q0.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL sb_m0: unexpected ready, required no response pending");
          end else begin
            e = q0.pop_front();
            chk32("sb_m0_rdata", m0_rdata, e.rd);
            chk1("sb_m0_timeout", timeout, e.to);
          end
        end
        if (m1_ready) begin
          if (q1.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL sb_m1: unexpected ready, required no response pending");
          end else begin
            e = q1.pop_front();
            chk32("sb_m1_rdata", m1_rdata, e.rd);
            chk1("sb_m1_timeout", timeout, e.to);
          end
        end
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    mv      = 2'b00;
    for (int i = 0; i < 2; i++) begin
      maddr[i] = 32'h0;
      mwd[i]   = 32'h0;
      mst[i]   = 4'h0;
    end
    s_ready = 1'b0;
    s_rdata = 32'h0;
    s_irq   = 1'b0;
    fork
      slave_loop();
      monitor_loop();
    join_none
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Single M0 read, slave answers two cycles after s_valid.
    @(posedge clk);
    #1;
    issue(0, 32'h0000_0100, 32'h0, 4'b0000, 2, 32'hDEAD_BEEF);

    // Pointer back to M0, then both masters stream four transfers.
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    fork
      begin
        issue(0, 32'h0000_1000, 32'h0, 4'b0000, 0, 32'hA000_0001);
        issue(0, 32'h0000_1004, 32'h0, 4'b0000, 0, 32'hA000_0002);
      end
      begin
        issue(1, 32'h0000_2000, 32'h0, 4'b0000, 0, 32'hB000_0001);
        issue(1, 32'h0000_2008, 32'h0, 4'b0000, 0, 32'hB000_0002);
      end
    join

    // M1 store while M0 holds an unrelated idle payload.
    maddr[0] = 32'hFFFF_0000;
    mwd[0]   = 32'hCAFE_CAFE;
    mst[0]   = 4'b1111;
    issue(1, 32'h0000_2004, 32'h1234_5678, 4'b0011, 1, 32'h5555_AAAA);

    // Watchdog abort on M0 with M1 arriving while M0 owns the bus.
    fork
      issue(0, 32'h0000_3000, 32'h0, 4'b0000, 20, 32'h7777_7777);
      begin
        @(posedge clk);
        #1;
        issue(1, 32'h0000_3004, 32'h0, 4'b0000, 0, 32'h8888_8888);
      end
    join

    // Completion in the same cycle the watchdog would fire.
    issue(0, 32'h0000_3008, 32'h0, 4'b0000, TMO - 1, 32'h0BAD_F00D);

    // Random traffic from both masters.
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        rnd_issue(0);
      end
      for (int j = 0; j < 25; j++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        rnd_issue(1);
      end
    join

    // Asynchronous reset in the second OWN1 cycle.
    @(posedge clk);
    #1;
    lat_map[32'h0000_5000] = 40;
    maddr[1] = 32'h0000_5000;
    mv[1]    = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk32("pre_reset_grant", 32'(grant), 32'h2);
    reset = 1'b0;
    #1;
    chk1("async_rst_s_valid", s_valid, 1'b0);
    chk32("async_rst_grant", 32'(grant), 32'h0);
    chk1("async_rst_m1_ready", m1_ready, 1'b0);
    mv[1] = 1'b0;
    @(posedge clk);
    #1;
    setup(0, 32'h0000_6000, 32'h0, 4'b0000, 1, 32'hC0DE_0000);
    setup(1, 32'h0000_6004, 32'h0, 4'b0000, 0, 32'hC0DE_0001);
    #2;
    reset = 1'b1;
    fork
      await_rdy(0);
      await_rdy(1);
    join

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/vermibus_arbiter.md
Name: vermibus_arbiter

Overview:
- Shares one Vermibus slave (memory/peripheral fabric) between two masters: M0 (the Vermicel core) and M1 (a DMA or debug master).
- Uses a registered round-robin grant, locked for the duration of one transfer, with a watchdog that aborts transfers the slave never acknowledges.
- Sits between the masters' Vermibus ports and the single slave-side port; the IRQ line passes through to M0 only.

Parameters:
- TIMEOUT, 256: maximum cycles a granted transfer may wait for s_ready before it is aborted; 0 disables the watchdog.
- M0_FIRST, 1: the master preferred by the round-robin pointer after reset (1 = M0, 0 = M1).

Ports:
- clk  in  1  clock.
- reset  in  1  reset; asynchronous, active-low.
- m0_valid, m1_valid  in  1  master requests a transfer; held stable with its payload until the matching mN_ready.
- m0_address, m1_address  in  32  byte address.
- m0_wdata, m1_wdata  in  32  store data.
- m0_wstrobe, m1_wstrobe  in  4  byte enables; all-zero means a read.
- m0_ready, m1_ready  out  1  transfer-complete strobe to that master.
- m0_rdata, m1_rdata  out  32  read data; valid in the cycle its mN_ready is 1.
- m0_irq  out  1  equal to s_irq (pass-through).
- s_valid  out  1  slave request.
- s_address  out  32  slave address.
- s_wdata  out  32  slave store data.
- s_wstrobe  out  4  slave byte enables.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data.
- s_irq  in  1  interrupt from the fabric.
- timeout  out  1  one-cycle pulse when a transfer is aborted.
- grant  out  2  one-hot current owner (bit0 = M0, bit1 = M1); 00 when idle.

Behaviour:
- FSM states: IDLE, OWN0, OWN1. Reset (asynchronous, while reset = 0) gives:
  - state = IDLE, grant = 00, s_valid = 0, timeout = 0;
  - both mN_ready = 0;
  - wait counter = 0;
  - priority pointer = M0 when M0_FIRST = 1, else M1.
- IDLE:
  - If only one mN_valid is 1, go to OWNN.
  - If both are 1, go to the master named by the pointer.
  - If neither is 1, stay in IDLE.
  - Arbitration costs exactly one cycle: the first possible s_valid is the cycle after the request is seen.
- OWNN:
  - s_valid = 1; s_address, s_wdata and s_wstrobe are driven from master N (combinational mux on the registered grant).
  - mN_ready = s_ready and mN_rdata = s_rdata, both combinational.
  - The other master sees ready = 0 and rdata = 0.
  - When s_ready = 1: return to IDLE next cycle; the pointer moves to the other master; the wait counter clears.
- Since IDLE is always visited between transfers, back-to-back requests alternate when both masters are pending. Throughput is at least one transfer per 2 cycles plus slave latency.
- Watchdog (TIMEOUT > 0):
  - The 16-bit wait counter increments each OWNN cycle with s_ready = 0.
  - When the counter equals TIMEOUT-1 and s_ready = 0, then in that cycle:
    - mN_ready = 1 and mN_rdata = 0;
    - s_valid is still 1;
    - timeout pulses;
    - next state = IDLE and the pointer advances.
  - If s_ready = 1 in the same cycle, the completion wins: there is no timeout pulse and s_rdata is returned.
- If master N drops valid while owning (a protocol violation), the transfer is still held until s_ready or timeout.
- s_valid = 0 in IDLE. There is no combinational path from mN_valid to s_valid.
- Asynchronous reset mid-transfer drops s_valid immediately; the in-flight transfer is lost and no ready is returned.
- m0_irq is purely combinational from s_irq, with no reset dependency.

Decomposition:
- Vermitypes_pkg (existing): word_t (32 bits) and the 4-bit strobe type; reuse them.
- New in Vermicel_pkg:
  - enum arb_state_t {IDLE, OWN0, OWN1};
  - localparam ARB_TIMEOUT_DEFAULT = 256.
- One sub-module, vermibus_watchdog: a counter with enable and clear inputs and an expired output, parameterised by TIMEOUT. It is reusable for other bus masters.
- Muxing and the FSM stay in the top module.

Test Plan:
- Single M0 read: M0 requests address 0x100; slave answers ready 2 cycles after s_valid with rdata 0xDEADBEEF.
  - Required: s_valid rises 1 cycle after m0_valid and s_address = 0x100.
  - Required: m0_ready = 1 with m0_rdata = 0xDEADBEEF; m1_ready stays 0; grant = 01 then 00.
- Simultaneous requests from reset (M0_FIRST = 1), both held for 4 transfers, slave always ready.
  - Required: grant sequence 01, 00, 10, 00, 01, 00, 10, i.e. strict alternation.
- M1 store: address 0x2004, wdata 0x12345678, wstrobe 0011.
  - Required: the slave sees exactly those values; m1_ready = 1 for one cycle; M0's payload never appears on the s_ bus.
- Timeout with TIMEOUT = 8: slave never ready, M0 reads.
  - Required: in the 8th OWN0 cycle, m0_ready = 1, m0_rdata = 0 and timeout pulses for 1 cycle.
  - Required: the next grant goes to M1 if M1 is pending.
- Boundary: s_ready arrives in the same cycle the counter hits TIMEOUT-1.
  - Required: no timeout pulse and s_rdata is returned.
- Reset asserted in the 2nd OWN1 cycle.
  - Required: s_valid = 0 and grant = 00 with no clock edge; after release, with both masters requesting, the first grant = 01.
